// File: rtl/minimips32_sys.sv
// MiniMIPS32 system I/O block: reset conditioning, DIP-switch synchroniser,
// 4x4 keypad column scanner with round-based debounce and key status outputs.
module minimips32_sys #(
    parameter int unsigned SCAN_CYCLES     = 16,
    parameter int unsigned DEBOUNCE_ROUNDS = 3
) (
    input  logic       clk_init,
    input  logic       rst_init,
    input  logic [7:0] switch,
    input  logic [3:0] btn_key_row,
    output logic [3:0] btn_key_col,
    output logic [7:0] switch_sync,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int unsigned DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_ROUNDS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_ROUNDS);

    typedef enum logic {
        SCAN_IDLE,
        SCAN_RUN
    } scan_state_e;

    // Reset: asserts asynchronously, releases two clocks after rst_init rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_init or negedge rst_init) begin
        if (!rst_init) rst_sync_q <= '0;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [7:0] sw_meta_q, sw_sync_q;
    logic [3:0] row_meta_q, row_sync_q;

    always_ff @(posedge clk_init or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            sw_meta_q  <= switch;
            sw_sync_q  <= sw_meta_q;
            row_meta_q <= btn_key_row;
            row_sync_q <= row_meta_q;
        end
    end

    assign switch_sync = sw_sync_q;

    scan_state_e   state_q;
    logic [1:0]    col_idx_q;
    logic [1:0]    col_next;
    logic [DW-1:0] dwell_q;
    logic [3:0]    btn_key_col_q;

    assign col_next = col_idx_q + 2'd1;

    always_ff @(posedge clk_init or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SCAN_IDLE;
            col_idx_q     <= '0;
            dwell_q       <= '0;
            btn_key_col_q <= '1;
        end else begin
            case (state_q)
                SCAN_IDLE: begin
                    state_q       <= SCAN_RUN;
                    btn_key_col_q <= 4'b1110;
                end
                SCAN_RUN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q       <= '0;
                        col_idx_q     <= col_next;
                        btn_key_col_q <= ~(4'b0001 << col_next);
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                default: state_q <= SCAN_IDLE;
            endcase
        end
    end

    assign btn_key_col = btn_key_col_q;

    // Only a clean 0 counts as pressed; X/Z fall into the else path as released.
    logic [3:0] row_low;
    logic       hit;
    logic [1:0] hit_row;

    always_comb begin
        row_low = '0;
        hit     = 1'b0;
        hit_row = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (row_sync_q[r] == 1'b0) row_low[r] = 1'b1;
        end
        for (int unsigned r = 0; r < 4; r++) begin
            if (row_low[r] && !hit) begin
                hit     = 1'b1;
                hit_row = 2'(r);
            end
        end
    end

    logic          sample_en, round_end;
    logic          found_q;
    logic [3:0]    found_code_q;
    logic          res_valid;
    logic [3:0]    res_code;
    logic          cand_valid_q;
    logic [3:0]    cand_code_q;
    logic [CW-1:0] cand_cnt_q, cand_cnt_d;
    logic          same_res, accept;
    logic [3:0]    key_code_q;
    logic          key_valid_q, key_pressed_q;

    assign sample_en = (state_q == SCAN_RUN) && (dwell_q == DWELL_LAST);
    assign round_end = sample_en && (col_idx_q == 2'd3);

    // Columns are visited in ascending order, so the first hit of a round wins.
    assign res_valid = found_q | hit;
    assign res_code  = found_q ? found_code_q : {hit_row, col_idx_q};
    assign same_res  = (res_valid == cand_valid_q) &&
                       (!res_valid || (res_code == cand_code_q));

    always_comb begin
        cand_cnt_d = CW'(1);
        if (same_res) begin
            cand_cnt_d = (cand_cnt_q >= CNT_MAX) ? CNT_MAX : cand_cnt_q + 1'b1;
        end
    end

    assign accept = (cand_cnt_d >= CNT_MAX);

    always_ff @(posedge clk_init or negedge rst_n) begin
        if (!rst_n) begin
            found_q       <= 1'b0;
            found_code_q  <= '0;
            cand_valid_q  <= 1'b0;
            cand_code_q   <= '0;
            cand_cnt_q    <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            key_pressed_q <= 1'b0;
            if (round_end) begin
                found_q      <= 1'b0;
                cand_valid_q <= res_valid;
                cand_code_q  <= res_code;
                cand_cnt_q   <= cand_cnt_d;
                if (accept) begin
                    if (res_valid && (!key_valid_q || (key_code_q != res_code))) begin
                        key_code_q    <= res_code;
                        key_valid_q   <= 1'b1;
                        key_pressed_q <= 1'b1;
                    end else if (!res_valid) begin
                        key_valid_q <= 1'b0;
                    end
                end
            end else if (sample_en && hit && !found_q) begin
                found_q      <= 1'b1;
                found_code_q <= {hit_row, col_idx_q};
            end
        end
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_minimips32_sys.sv
// Self-checking bench for minimips32_sys: keypad matrix model, random key sets
// and switch values checked against a behavioural scan-priority reference.
module tb_minimips32_sys;

    logic       clk_init = 1'b0;
    logic       rst_init;
    logic [7:0] switch;
    logic [3:0] btn_key_row;
    logic [3:0] btn_key_col;
    logic [7:0] switch_sync;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    int n_cmp = 0;
    int n_err = 0;

    logic        use_matrix;
    logic [15:0] key_mask;
    logic [3:0]  static_row;

    bit          model_valid;
    logic [3:0]  model_code;

    minimips32_sys #(.SCAN_CYCLES(16), .DEBOUNCE_ROUNDS(3)) dut (
        .clk_init   (clk_init),
        .rst_init   (rst_init),
        .switch     (switch),
        .btn_key_row(btn_key_row),
        .btn_key_col(btn_key_col),
        .switch_sync(switch_sync),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_pressed(key_pressed)
    );

    always #5 clk_init = ~clk_init;

    // Keypad: a held key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        btn_key_row = static_row;
        if (use_matrix) begin
            btn_key_row = 4'b1111;
            for (int c = 0; c < 4; c++)
                if (btn_key_col[c] == 1'b0)
                    for (int r = 0; r < 4; r++)
                        if (key_mask[r*4+c]) btn_key_row[r] = 1'b0;
        end
    end

    function automatic void ref_scan(input logic [15:0] mask, output bit v, output logic [3:0] code);
        v = 0;
        code = 4'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!v && mask[r*4+c]) begin
                    v = 1;
                    code = 4'(r*4 + c);
                end
    endfunction

    task automatic wait_press(input int budget, output int cycles, output bit got);
        got = 0;
        cycles = 0;
        while (!got && cycles < budget) begin
            @(negedge clk_init);
            cycles++;
            if (key_pressed === 1'b1) got = 1;
        end
    endtask

    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_init);
            if (key_pressed === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        logic [3:0] pat;
        bit seen;
        rst_init = 1'b0;
        use_matrix = 1'b0;
        static_row = 4'b1111;
        key_mask = '0;
        switch = 8'h3D;
        #1050;
        @(negedge clk_init);
        n_cmp++; if (btn_key_col !== 4'b1111) begin n_err++; $display("FAIL reset_col: got %b expected 1111", btn_key_col); end
        n_cmp++; if (switch_sync !== 8'h00) begin n_err++; $display("FAIL reset_sw: got %h expected 00", switch_sync); end
        n_cmp++; if (key_code !== 4'h0) begin n_err++; $display("FAIL reset_code: got %h expected 0", key_code); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        n_cmp++; if (key_pressed !== 1'b0) begin n_err++; $display("FAIL reset_pressed: got %b expected 0", key_pressed); end
        rst_init = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clk_init);
            if (btn_key_col === 4'b1110) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL first_scan: got %b expected 1110 within 3 clocks", btn_key_col); end
        for (int k = 0; k < 4; k++) begin
            pat = 4'b1111 ^ (4'b0001 << k);
            cnt = 0;
            while (btn_key_col === pat && cnt < 100) begin
                cnt++;
                @(negedge clk_init);
            end
            n_cmp++; if (cnt != 16) begin n_err++; $display("FAIL col%0d_dwell: got %0d expected 16", k, cnt); end
        end
        n_cmp++; if (btn_key_col !== 4'b1110) begin n_err++; $display("FAIL col_wrap: got %b expected 1110", btn_key_col); end
        n_cmp++; if (switch_sync !== 8'h3D) begin n_err++; $display("FAIL sw_after_reset: got %h expected 3D", switch_sync); end
    endtask

    task automatic test_switches();
        logic [7:0] v, old;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_init);
            old = switch;
            v = 8'($urandom);
            if (v == old) v = ~old;
            switch = v;
            @(negedge clk_init);
            n_cmp++; if (switch_sync !== old) begin n_err++; $display("FAIL sw_lat1: got %h expected %h", switch_sync, old); end
            @(negedge clk_init);
            n_cmp++; if (switch_sync !== v) begin n_err++; $display("FAIL sw_lat2: got %h expected %h", switch_sync, v); end
        end
    endtask

    task automatic test_x_rows();
        logic [3:0] xv;
        int pulses;
        xv = 4'bxxxx;
        if (^xv === 1'bx) static_row = 4'bxxxx;
        else              static_row = 4'b1111;
        run_count(500, pulses);
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL x_pulses: got %0d expected 0", pulses); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL x_valid: got %b expected 0", key_valid); end
    endtask

    task automatic test_first_key();
        int cyc, pulses;
        bit got;
        static_row = 4'b1110;
        wait_press(258, cyc, got);
        n_cmp++; if (!got) begin n_err++; $display("FAIL key1_press: got no pulse expected pulse within 258"); end
        n_cmp++; if (key_code !== 4'h0) begin n_err++; $display("FAIL key1_code: got %h expected 0", key_code); end
        n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL key1_valid: got %b expected 1", key_valid); end
        @(negedge clk_init);
        n_cmp++; if (key_pressed !== 1'b0) begin n_err++; $display("FAIL key1_width: got %b expected 0", key_pressed); end
        run_count(400, pulses);
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL key1_hold: got %0d pulses expected 0", pulses); end
        n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL key1_held_valid: got %b expected 1", key_valid); end
    endtask

    task automatic test_second_key();
        int cyc, pulses;
        bit got;
        run_count(600, pulses);
        static_row = 4'b0111;
        wait_press(258, cyc, got);
        n_cmp++; if (!got) begin n_err++; $display("FAIL key2_press: got no pulse expected pulse within 258"); end
        n_cmp++; if (key_code !== 4'hC) begin n_err++; $display("FAIL key2_code: got %h expected C", key_code); end
        run_count(200, pulses);
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL key2_hold: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_release();
        int cyc;
        bit cleared;
        static_row = 4'b1111;
        for (int i = 0; i < 128; i++) @(negedge clk_init);
        n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL rel_early: got %b expected 1", key_valid); end
        cleared = 0;
        cyc = 0;
        while (!cleared && cyc < 200) begin
            @(negedge clk_init);
            cyc++;
            if (key_valid === 1'b0) cleared = 1;
        end
        n_cmp++; if (!cleared) begin n_err++; $display("FAIL rel_clear: got %b expected 0", key_valid); end
        n_cmp++; if (key_code !== 4'hC) begin n_err++; $display("FAIL rel_code: got %h expected C", key_code); end
        model_valid = 0;
        model_code = 4'hC;
    endtask

    task automatic test_random_keys();
        int cyc, pulses;
        bit got, ev;
        logic [3:0] ec;
        logic [15:0] m;
        use_matrix = 1'b1;
        for (int it = 0; it < 8; it++) begin
            m = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) m |= 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) m |= 16'(1) << $urandom_range(0, 15);
            ref_scan(m, ev, ec);
            key_mask = m;
            if (model_valid && model_code == ec) begin
                run_count(300, pulses);
                n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rnd_same_pulse: got %0d expected 0 (mask %h)", pulses, m); end
            end else begin
                wait_press(258, cyc, got);
                n_cmp++; if (!got) begin n_err++; $display("FAIL rnd_press: got no pulse expected pulse (mask %h)", m); end
            end
            n_cmp++; if (key_code !== ec) begin n_err++; $display("FAIL rnd_code: got %h expected %h (mask %h)", key_code, ec, m); end
            n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL rnd_valid: got %b expected 1", key_valid); end
            model_valid = 1;
            model_code = ec;
            for (int i = 0; i < 10; i++) @(negedge clk_init);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        bit got, seen;
        bit ev;
        logic [3:0] ec;
        ref_scan(key_mask, ev, ec);
        cyc = 0;
        while (btn_key_col !== 4'b1011 && cyc < 100) begin
            @(negedge clk_init);
            cyc++;
        end
        #3;
        rst_init = 1'b0;
        #1;
        n_cmp++; if (btn_key_col !== 4'b1111) begin n_err++; $display("FAIL mrst_col: got %b expected 1111", btn_key_col); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b expected 0", key_valid); end
        n_cmp++; if (key_code !== 4'h0) begin n_err++; $display("FAIL mrst_code: got %h expected 0", key_code); end
        n_cmp++; if (switch_sync !== 8'h00) begin n_err++; $display("FAIL mrst_sw: got %h expected 00", switch_sync); end
        n_cmp++; if (key_pressed !== 1'b0) begin n_err++; $display("FAIL mrst_pressed: got %b expected 0", key_pressed); end
        @(negedge clk_init);
        @(negedge clk_init);
        rst_init = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clk_init);
            if (btn_key_col === 4'b1110) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL mrst_restart: got %b expected 1110 within 3 clocks", btn_key_col); end
        wait_press(300, cyc, got);
        n_cmp++; if (!got || cyc < 150) begin n_err++; $display("FAIL mrst_repress: got pulse=%0d after %0d cycles expected pulse after 150..300", got, cyc); end
        n_cmp++; if (key_code !== ec) begin n_err++; $display("FAIL mrst_code2: got %h expected %h", key_code, ec); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_valid = 0;
        model_code = 4'h0;
        test_reset();
        test_switches();
        test_x_rows();
        test_first_key();
        test_second_key();
        test_release();
        test_random_keys();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
